// File: rtl/mem_bus_pkg.sv
// Shared widths and word types for the CPU multiplexed address/data memory bus.
// Used by tagged_mem_responder and tagged_ram.
package mem_bus_pkg;
  localparam int WORD_W         = 64;
  localparam int TAG_W_DEF      = 8;
  localparam int MAX_RD_LATENCY = 4;

  typedef logic [WORD_W-1:0]    word_t;
  typedef logic [TAG_W_DEF-1:0] tag_t;

  typedef struct packed {
    tag_t  tag;
    word_t data;
  } tword_t;
endpackage

// File: rtl/tagged_ram.sv
// Single-port synchronous tagged word array with a registered read port.
// The read register holds its value until the next read, so it maps to block RAM.
module tagged_ram
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = 20,
  parameter int DATA_W = WORD_W + TAG_W_DEF
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/tagged_mem_responder.sv
// Tagged 64-bit memory responder: address latch, store/load priority, read latency pipe.
// Optional TAGGED_MEM_BURST_EN: address auto-increments after each executed rd/wr.
module tagged_mem_responder
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W     = 20,
  parameter int RD_LATENCY = 1,
  parameter int TAG_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [63:0]      i_ad,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_astb,
  input  logic             i_rd,
  input  logic             i_wr,
  output logic [63:0]      o_data,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_valid,
  output logic             o_busy
);

  localparam int TW_W = WORD_W + TAG_W;

  logic [ADDR_W-1:0]     waddr_q, waddr_d;
  logic                  wr_go, rd_go;
  logic [TW_W-1:0]       rdata;
  logic [TW_W-1:0]       tap;
  logic [RD_LATENCY-1:0] vld_q;
  word_t                 data_q;
  logic [TAG_W-1:0]      tag_q;
  logic                  valid_q;

  assign wr_go = !reset && !i_astb && i_wr;
  assign rd_go = !reset && !i_astb && !i_wr && i_rd;

  always_comb begin
    waddr_d = waddr_q;
    if (i_astb) begin
      waddr_d = i_ad[ADDR_W-1:0];
    end
`ifdef TAGGED_MEM_BURST_EN
    else if (wr_go || rd_go) begin
      waddr_d = waddr_q + ADDR_W'(1);
    end
`endif
  end

  tagged_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(TW_W)
  ) u_ram (
    .clk    (clk),
    .we_i   (wr_go),
    .re_i   (rd_go),
    .addr_i (waddr_q),
    .wdata_i({i_tag, i_ad}),
    .rdata_o(rdata)
  );

  // RAM output register is stage 0; extra stages stretch to RD_LATENCY.
  generate
    if (RD_LATENCY > 1) begin : g_dly
      logic [TW_W-1:0] dly_q [RD_LATENCY-1];
      always_ff @(posedge clk) begin
        dly_q[0] <= rdata;
        for (int i = 1; i < RD_LATENCY - 1; i++) begin
          dly_q[i] <= dly_q[i-1];
        end
      end
      assign tap = dly_q[RD_LATENCY-2];
    end else begin : g_nodly
      assign tap = rdata;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      waddr_q <= '0;
      vld_q   <= '0;
      data_q  <= '0;
      tag_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      waddr_q  <= waddr_d;
      vld_q[0] <= rd_go;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
      valid_q <= vld_q[RD_LATENCY-1];
      if (vld_q[RD_LATENCY-1]) begin
        {tag_q, data_q} <= tap;
      end
    end
  end

  assign o_data  = data_q;
  assign o_tag   = tag_q;
  assign o_valid = valid_q;
  assign o_busy  = |vld_q;

endmodule

// File: doc/tagged_mem_responder.md
Name: tagged_mem_responder

Overview:
- Synthesizable responder for the CPU's multiplexed address/data memory bus.
- Latches a word address on an address strobe, then performs a tagged 64-bit store or load on later strobes.
- Load data is returned after a fixed configurable latency; the last load result is held on the CPU's data/tag inputs.
- Replaces the behavioural bench RAM so memtest can run on FPGA and in gate-level simulation.

Parameters:
- ADDR_W, 20: word-address width; depth is 2**ADDR_W words.
- RD_LATENCY, 1: cycles from the read strobe to data valid; legal range 1..4.
- TAG_W, 8: tag width per word.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- i_ad  in  64  address/data from CPU o_ad
- i_tag  in  TAG_W  tag from CPU o_tag
- i_astb  in  1  address strobe
- i_rd  in  1  read request
- i_wr  in  1  write request
- o_data  out  64  load data to CPU i_data; held between loads
- o_tag  out  TAG_W  load tag to CPU i_tag; held between loads
- o_valid  out  1  one-cycle pulse when o_data/o_tag update
- o_busy  out  1  high while any read is in flight in the latency pipe

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values:
  - o_data=0, o_tag=0, o_valid=0, o_busy=0.
  - Latched address waddr=0; read pipe flushed.
  - RAM contents are not cleared.
- Per-cycle priority, evaluated on posedge clk:
  - i_astb: waddr <= i_ad[ADDR_W-1:0]; upper i_ad bits are ignored; i_wr and i_rd are ignored that cycle.
  - else i_wr: mem[waddr] <= {i_tag, i_ad}; i_rd is ignored.
  - else i_rd: array read of mem[waddr] issued; result enters the pipe.
- Read pipe:
  - A valid/data shift register of depth RD_LATENCY.
  - Data is sampled from the array in the issue cycle. A write to the same address in a later cycle does not alter an in-flight read.
  - With RD_LATENCY=1: read strobe at edge N gives o_data/o_tag/o_valid updated at edge N+1.
  - Back-to-back reads are fully pipelined, one result per cycle.
  - o_busy = OR of the pipe valid bits.
- Hold: o_data/o_tag change only when the pipe output is valid, otherwise they hold. o_valid is low in all other cycles.
- Address wrap: addresses are modulo 2**ADDR_W. No error is signalled.
- Reset mid-read: the pipe is cleared and no o_valid is produced for discarded reads.
- Write-then-read at the same address in consecutive cycles returns the new data.

Optional Feature:
- Macro: TAGGED_MEM_BURST_EN.
- Defined: after every executed i_rd or i_wr that is not overridden by i_astb, waddr <= waddr+1, wrapping at 2**ADDR_W. This supports block-transfer sequences without a new address strobe.
- Undefined: waddr changes only on i_astb, which is the baseline protocol.

Decomposition:
- Shared package mem_bus_pkg holds:
  - WORD_W=64 and TAG_W_DEF=8.
  - Typedefs word_t, tag_t, and tword_t (packed {tag_t, word_t}).
  - MAX_RD_LATENCY=4.
- Sub-module tagged_ram:
  - Single-port synchronous 72-bit x 2**ADDR_W array; one read or write per cycle.
  - Registered read output so it maps to block RAM.
- The responder wraps tagged_ram with the address latch, priority logic and latency pipe.

Test Plan:
- Store then load:
  - astb addr=0x00123, then wr ad=0xDEADBEEF_01234567 tag=0x5A, then astb 0x00123, then rd.
  - With RD_LATENCY=1: o_valid pulses one cycle after rd, o_data=0xDEADBEEF_01234567, o_tag=0x5A; both hold afterwards.
- Priority:
  - astb=1 and wr=1 in the same cycle with ad=0x7 updates waddr to 7 and performs no write.
  - wr=1 and rd=1 together writes only; no o_valid follows.
- Latency and pipelining:
  - RD_LATENCY=3, four back-to-back reads of preloaded addresses 0..3 (one astb before each, or using burst).
  - Four consecutive o_valid pulses starting 3 cycles after the first rd, with data in order; o_busy high throughout.
- Reset mid-read:
  - RD_LATENCY=4, rd issued, reset asserted 2 cycles later.
  - No o_valid; o_data=0, o_tag=0, o_busy=0; previously stored memory is still readable after reset.
- Address wrap/truncation:
  - astb ad=0xFFFF_FFFF_FFF0_0005 accesses word 0x00005.
  - With TAGGED_MEM_BURST_EN: a write at 0xFFFFF followed by a write with no astb lands at 0x00000.
- Write-after-issued-read:
  - rd of addr 9 (old value 0x1111), then astb 9 and wr 0x2222.
  - The in-flight result is 0x1111; a subsequent read returns 0x2222.
